// File: rtl/key_sched_ctrl_pkg.sv
// rtl/key_sched_ctrl_pkg.sv - shared AES key-schedule constants, FSM encoding and Rcon table
package key_sched_ctrl_pkg;
   localparam int AES_KEY_LEN    = 128;
   localparam int AES_WORD_LEN   = 32;
   localparam int AES_NUM_ROUNDS = 10;
   localparam int RK_ADDR_W      = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_DONE,
      ST_ERR
   } ks_state_t;

   // Rcon word for rounds 1..10; any other index yields zero.
   function automatic logic [31:0] rcon_word(input logic [3:0] round);
      logic [7:0] rc;
      case (round)
         4'd1:    rc = 8'h01;
         4'd2:    rc = 8'h02;
         4'd3:    rc = 8'h04;
         4'd4:    rc = 8'h08;
         4'd5:    rc = 8'h10;
         4'd6:    rc = 8'h20;
         4'd7:    rc = 8'h40;
         4'd8:    rc = 8'h80;
         4'd9:    rc = 8'h1B;
         4'd10:   rc = 8'h36;
         default: rc = 8'h00;
      endcase
      return {rc, 24'h0};
   endfunction
endpackage

// File: rtl/key_sched_ctrl_rk_store.sv
// rtl/key_sched_ctrl_rk_store.sv - round-key store, one sync write port and one registered read port
module rk_store #(
   parameter int KEY_LEN = 128,
   parameter int DEPTH   = 11,
   parameter int AW      = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               wr_en,
   input  logic [AW-1:0]      wr_addr,
   input  logic [KEY_LEN-1:0] wr_data,
   input  logic [AW-1:0]      rd_addr,
   output logic [KEY_LEN-1:0] rd_data
);
   logic [KEY_LEN-1:0] mem [DEPTH];

   // Contents survive reset; the controller's keys_valid flag says whether they are current.
   always_ff @(posedge clk) begin
      if (wr_en && (wr_addr < AW'(DEPTH))) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         rd_data <= '0;
      end else if (rd_addr < AW'(DEPTH)) begin
         rd_data <= mem[rd_addr];
      end else begin
         rd_data <= '0;
      end
   end
endmodule

// File: rtl/key_sched_ctrl.sv
// rtl/key_sched_ctrl.sv - AES-128 key-schedule controller driving an external round-key generator
module key_sched_ctrl
   import key_sched_ctrl_pkg::*;
#(
   parameter int KEY_LEN    = AES_KEY_LEN,
   parameter int WORD_LEN   = AES_WORD_LEN,
   parameter int NUM_ROUNDS = AES_NUM_ROUNDS,
   parameter int TIMEOUT    = 15
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [KEY_LEN-1:0]   cipher_key,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic                 keys_valid,
   output logic                 gk_valid_in,
   output logic [KEY_LEN-1:0]   gk_key_in,
   output logic [WORD_LEN-1:0]  gk_rcon,
   input  logic [KEY_LEN-1:0]   gk_round_key,
   input  logic                 gk_valid_out,
   input  logic [RK_ADDR_W-1:0] rk_rd_addr,
   output logic [KEY_LEN-1:0]   rk_rd_data
);
   localparam int CW = $clog2(TIMEOUT + 1);

   ks_state_t              state;
   logic [RK_ADDR_W-1:0]   round;
   logic [CW-1:0]          wait_cnt;

   logic                   st_wr_en;
   logic [RK_ADDR_W-1:0]   st_wr_addr;
   logic [KEY_LEN-1:0]     st_wr_data;

   // Store writes happen only on an accepted start or a generator response taken in WAIT.
   always_comb begin
      st_wr_en   = 1'b0;
      st_wr_addr = '0;
      st_wr_data = cipher_key;
      if (reset) begin
         if (state == ST_IDLE && start) begin
            st_wr_en = 1'b1;
         end else if (state == ST_WAIT && gk_valid_out) begin
            st_wr_en   = 1'b1;
            st_wr_addr = round;
            st_wr_data = gk_round_key;
         end
      end
   end

   // gk_key_in/gk_rcon only change when entering ISSUE, so they hold through the whole WAIT.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= ST_IDLE;
         round       <= '0;
         wait_cnt    <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
         keys_valid  <= 1'b0;
         gk_valid_in <= 1'b0;
         gk_key_in   <= '0;
         gk_rcon     <= '0;
      end else begin
         done        <= 1'b0;
         err         <= 1'b0;
         gk_valid_in <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  round       <= RK_ADDR_W'(1);
                  keys_valid  <= 1'b0;
                  busy        <= 1'b1;
                  gk_valid_in <= 1'b1;
                  gk_key_in   <= cipher_key;
                  gk_rcon     <= WORD_LEN'(rcon_word(4'd1));
                  state       <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               wait_cnt <= '0;
               state    <= ST_WAIT;
            end
            ST_WAIT: begin
               if (gk_valid_out) begin
                  if (round == RK_ADDR_W'(NUM_ROUNDS)) begin
                     busy       <= 1'b0;
                     done       <= 1'b1;
                     keys_valid <= 1'b1;
                     state      <= ST_DONE;
                  end else begin
                     round       <= round + RK_ADDR_W'(1);
                     gk_valid_in <= 1'b1;
                     gk_key_in   <= gk_round_key;
                     gk_rcon     <= WORD_LEN'(rcon_word(round + RK_ADDR_W'(1)));
                     state       <= ST_ISSUE;
                  end
               end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                  busy  <= 1'b0;
                  err   <= 1'b1;
                  state <= ST_ERR;
               end else begin
                  wait_cnt <= wait_cnt + CW'(1);
               end
            end
            ST_DONE, ST_ERR: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   rk_store #(
      .KEY_LEN (KEY_LEN),
      .DEPTH   (NUM_ROUNDS + 1),
      .AW      (RK_ADDR_W)
   ) u_rk_store (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (st_wr_en),
      .wr_addr (st_wr_addr),
      .wr_data (st_wr_data),
      .rd_addr (rk_rd_addr),
      .rd_data (rk_rd_data)
   );
endmodule

// File: tb/tb_key_sched_ctrl.sv
// tb/tb_key_sched_ctrl.sv - scoreboard bench for key_sched_ctrl with a behavioural AES round-key generator
module tb_key_sched_ctrl;
   localparam int TIMEOUT = 15;
   localparam int GEN_LAT = 3;
   localparam int RUN_LEN = 40;

   localparam logic [127:0] K1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] K1_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] K1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] K2     = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] K2_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
   localparam logic [127:0] K_STRAY = 128'hffeeddccbbaa99887766554433221100;
   localparam logic [127:0] JUNK   = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
   localparam logic [7:0] RC_TAB [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                          8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   logic          clk;
   logic          reset;
   logic          start;
   logic [127:0]  cipher_key;
   logic          busy, done, err, keys_valid, gk_valid_in;
   logic [127:0]  gk_key_in;
   logic [31:0]   gk_rcon;
   logic [127:0]  gk_round_key;
   logic          gk_valid_out;
   logic [3:0]    rk_rd_addr;
   logic [127:0]  rk_rd_data;

   typedef struct {
      bit is_err;
      int delay;
   } evt_t;

   logic [31:0]  rcon_q [$];
   evt_t         evt_q [$];
   logic [127:0] rd_q [$];

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   first_issue = 0;
   logic rd_req, rd_pend;
   logic gen_en, inj_req;
   logic hold_active;
   logic [31:0] cur_rcon;

   key_sched_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .cipher_key   (cipher_key),
      .busy         (busy),
      .done         (done),
      .err          (err),
      .keys_valid   (keys_valid),
      .gk_valid_in  (gk_valid_in),
      .gk_key_in    (gk_key_in),
      .gk_rcon      (gk_rcon),
      .gk_round_key (gk_round_key),
      .gk_valid_out (gk_valid_out),
      .rk_rd_addr   (rk_rd_addr),
      .rk_rd_data   (rk_rd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      rd_pend <= rd_req;
   end

   function automatic logic [7:0] sbox_lu(input logic [7:0] b);
      return SBOX[2047 - 8 * int'(b) -: 8];
   endfunction

   function automatic logic [127:0] aes_next(input logic [127:0] k, input logic [31:0] rc);
      logic [31:0] w0, w1, w2, w3, t;
      {w0, w1, w2, w3} = k;
      t  = {sbox_lu(w3[23:16]), sbox_lu(w3[15:8]), sbox_lu(w3[7:0]), sbox_lu(w3[31:24])} ^ rc;
      w0 = w0 ^ t;
      w1 = w1 ^ w0;
      w2 = w2 ^ w1;
      w3 = w3 ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Generator model: samples the key at issue, uses gk_rcon late at its response cycle.
   initial begin
      gk_valid_out = 1'b0;
      gk_round_key = '0;
      forever begin
         logic [127:0] k;
         @(negedge clk);
         gk_valid_out = 1'b0;
         if (inj_req) begin
            gk_round_key = JUNK;
            gk_valid_out = 1'b1;
         end else if (gk_valid_in && gen_en) begin
            k = gk_key_in;
            repeat (GEN_LAT) @(negedge clk);
            gk_round_key = aes_next(k, gk_rcon);
            gk_valid_out = 1'b1;
         end
      end
   end

   // Monitor: pops the scoreboards whenever the DUT presents an issue, an end event or read data.
   initial hold_active = 1'b0;
   always @(negedge clk) begin
      if (gk_valid_in) begin
         if (rcon_q.size() == 0) begin
            check("unexpected_issue", 128'(1), 128'(0));
         end else begin
            cur_rcon = rcon_q.pop_front();
            check("gk_rcon_issue", 128'(gk_rcon), 128'(cur_rcon));
            hold_active = 1'b1;
            if (cur_rcon == 32'h01000000) first_issue = cyc;
         end
      end else if (busy && hold_active) begin
         check("gk_rcon_hold", 128'(gk_rcon), 128'(cur_rcon));
      end
      if (!busy && !gk_valid_in) hold_active = 1'b0;
      if (done || err) begin
         if (evt_q.size() == 0) begin
            check("unexpected_done_err", 128'(1), 128'(0));
         end else begin
            evt_t ev;
            ev = evt_q.pop_front();
            check("end_kind_err", 128'(err), 128'(ev.is_err));
            check("end_kind_done", 128'(done), 128'(!ev.is_err));
            check("end_delay", 128'(cyc - first_issue), 128'(ev.delay));
            check("busy_at_end", 128'(busy), 128'(0));
            check("keys_valid_at_end", 128'(keys_valid), 128'(!ev.is_err));
         end
      end
      if (rd_pend) begin
         if (rd_q.size() == 0) check("unexpected_read", 128'(1), 128'(0));
         else check("rk_rd_data", rk_rd_data, rd_q.pop_front());
      end
   end

   task automatic push_run(input int n_rcon, input bit has_evt, input bit is_err, input int delay);
      evt_t ev;
      for (int i = 0; i < n_rcon; i++) rcon_q.push_back({RC_TAB[i], 24'h0});
      if (has_evt) begin
         ev.is_err = is_err;
         ev.delay  = delay;
         evt_q.push_back(ev);
      end
   endtask

   task automatic pulse_start(input logic [127:0] key);
      @(negedge clk);
      start      = 1'b1;
      cipher_key = key;
      @(negedge clk);
      start      = 1'b0;
   endtask

   task automatic do_read(input logic [3:0] addr, input logic [127:0] exp);
      @(negedge clk);
      rk_rd_addr = addr;
      rd_q.push_back(exp);
      rd_req = 1'b1;
      @(negedge clk);
      rd_req = 1'b0;
   endtask

   task automatic wait_end();
      int n = 0;
      while (!(done || err) && n < 300) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 300) begin
         errors++;
         $display("FAIL wait_end: no done/err within %0d cycles", n);
      end
   endtask

   task automatic wait_issue(input logic [31:0] rc);
      int n = 0;
      while (!(gk_valid_in && gk_rcon == rc) && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 200) begin
         errors++;
         $display("FAIL wait_issue: no issue with rcon %h within %0d cycles", rc, n);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b0; start = 1'b0; cipher_key = '0; rk_rd_addr = '0;
      rd_req = 1'b0; gen_en = 1'b1; inj_req = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", 128'(busy), 128'(0));
      check("rst_done", 128'(done), 128'(0));
      check("rst_err", 128'(err), 128'(0));
      check("rst_keys_valid", 128'(keys_valid), 128'(0));
      check("rst_gk_valid_in", 128'(gk_valid_in), 128'(0));
      check("rst_gk_key_in", gk_key_in, 128'(0));
      check("rst_gk_rcon", 128'(gk_rcon), 128'(0));
      check("rst_rk_rd_data", rk_rd_data, 128'(0));
      reset = 1'b1;
      @(negedge clk);

      // FIPS-197 expansion with the real generator
      push_run(10, 1'b1, 1'b0, RUN_LEN);
      pulse_start(K1);
      wait_end();
      @(negedge clk);
      check("keys_valid_after_done", 128'(keys_valid), 128'(1));
      do_read(4'd1, K1_R1);
      do_read(4'd10, K1_R10);
      do_read(4'd0, K1);
      do_read(4'd11, 128'(0));
      do_read(4'd15, 128'(0));

      // stray generator response while idle
      @(negedge clk); #1 inj_req = 1'b1;
      @(negedge clk); #1 inj_req = 1'b0;
      do_read(4'd1, K1_R1);
      do_read(4'd0, K1);
      check("keys_valid_after_stray", 128'(keys_valid), 128'(1));

      // second start during round 5 is ignored
      push_run(10, 1'b1, 1'b0, RUN_LEN);
      pulse_start(K1);
      wait_issue(32'h10000000);
      @(negedge clk);
      start = 1'b1; cipher_key = K_STRAY;
      @(negedge clk);
      start = 1'b0;
      wait_end();
      do_read(4'd0, K1);
      do_read(4'd10, K1_R10);

      // silent generator: timeout
      gen_en = 1'b0;
      push_run(1, 1'b1, 1'b1, TIMEOUT + 1);
      pulse_start(K2);
      wait_end();
      @(negedge clk);
      check("keys_valid_after_err", 128'(keys_valid), 128'(0));
      check("busy_after_err", 128'(busy), 128'(0));
      gen_en = 1'b1;

      // reset in round 4, then a fresh run
      push_run(4, 1'b0, 1'b0, 0);
      pulse_start(K1);
      wait_issue(32'h08000000);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      check("busy_after_midrst", 128'(busy), 128'(0));
      check("gk_rcon_after_midrst", 128'(gk_rcon), 128'(0));
      check("keys_valid_after_midrst", 128'(keys_valid), 128'(0));
      repeat (6) @(negedge clk);
      do_read(4'd0, K1);
      push_run(10, 1'b1, 1'b0, RUN_LEN);
      @(negedge clk);
      start = 1'b1; cipher_key = K2;
      rk_rd_addr = 4'd0; rd_q.push_back(K1); rd_req = 1'b1;
      @(negedge clk);
      start = 1'b0; rd_req = 1'b0;
      wait_end();
      do_read(4'd10, K2_R10);
      do_read(4'd0, K2);
      check("keys_valid_final", 128'(keys_valid), 128'(1));

      repeat (3) @(negedge clk);
      check("rcon_q_drained", 128'(rcon_q.size()), 128'(0));
      check("evt_q_drained", 128'(evt_q.size()), 128'(0));
      check("rd_q_drained", 128'(rd_q.size()), 128'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/key_sched_ctrl.md
KEY_SCHED_CTRL -- requirements
Module: key_sched_ctrl

Interface
REQ-001 Parameter KEY_LEN, default 128, AES-128 key and round-key width in bits.
REQ-002 Parameter WORD_LEN, default 32, key-schedule word width.
REQ-003 Parameter NUM_ROUNDS, default 10, number of round keys generated after the cipher key.
REQ-004 Parameter TIMEOUT, default 15, maximum cycles to wait for a round key.
REQ-005 clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 reset  in  1  synchronous, active-low; sampled on the rising edge of clk.
REQ-007 start  in  1  single-cycle request to expand cipher_key.
REQ-008 cipher_key  in  KEY_LEN  AES-128 cipher key, sampled only when start is accepted.
REQ-009 busy  out  1  high from an accepted start until DONE or ERR.
REQ-010 done  out  1  one-cycle pulse when all round keys are stored.
REQ-011 err  out  1  one-cycle pulse on a round-key timeout.
REQ-012 keys_valid  out  1  high when the key store holds a complete schedule.
REQ-013 gk_valid_in  out  1  one-cycle issue pulse to the round-key generator.
REQ-014 gk_key_in  out  KEY_LEN  previous round key sent to the generator.
REQ-015 gk_rcon  out  WORD_LEN  round constant sent to the generator.
REQ-016 gk_round_key  in  KEY_LEN  round key returned by the generator.
REQ-017 gk_valid_out  in  1  qualifies gk_round_key.
REQ-018 rk_rd_addr  in  4  key-store read index, 0 to NUM_ROUNDS.
REQ-019 rk_rd_data  out  KEY_LEN  key-store read data, registered, one-cycle latency.

Function
REQ-020 FSM states SHALL be IDLE, ISSUE, WAIT, DONE and ERR.
REQ-021 In IDLE, start=1 SHALL write cipher_key to store[0], set round=1, clear keys_valid and move to ISSUE.
REQ-022 ISSUE SHALL assert gk_valid_in for exactly one cycle, with gk_key_in=store[round-1] and gk_rcon=RCON[round], then move to WAIT.
REQ-023 gk_key_in and gk_rcon SHALL stay stable from ISSUE until gk_valid_out is taken, because the generator consumes Rcon combinationally at its late stage.
REQ-024 RCON[1..10] SHALL be {rc,24'h0}, with rc = 01,02,04,08,10,20,40,80,1B,36 (hex).
REQ-025 In WAIT, gk_valid_out=1 SHALL write gk_round_key to store[round].
  - If round=NUM_ROUNDS: go to DONE.
  - Otherwise: increment round and go to ISSUE (one idle cycle between issues).
REQ-026 The WAIT cycle counter SHALL reset on entry to WAIT; if it reaches TIMEOUT with no gk_valid_out, go to ERR.
REQ-027 DONE SHALL pulse done, set keys_valid and return to IDLE next cycle.
REQ-028 ERR SHALL pulse err, leave keys_valid=0 and return to IDLE next cycle.
REQ-029 start while busy=1 SHALL be ignored with no side effect.
REQ-030 gk_valid_out outside WAIT SHALL be ignored and SHALL NOT write the store.
REQ-031 Reads SHALL be allowed in any state; they return the current store contents.
REQ-032 rk_rd_addr > NUM_ROUNDS SHALL return all zeros.
REQ-033 A write and a read to the same index in the same cycle SHALL return the old data.

Reset
REQ-034 reset=0 at a clock edge SHALL force:
  - state IDLE, round 0, wait counter 0;
  - busy, done, err, keys_valid and gk_valid_in to 0;
  - gk_key_in, gk_rcon and rk_rd_data to 0.
REQ-035 Reset SHALL NOT clear the key store; keys_valid=0 marks its contents stale.
REQ-036 Reset mid-expansion SHALL abandon the run; a late gk_valid_out after reset SHALL be ignored.

Structure
REQ-037 The RCON table, state encoding and KEY_LEN/WORD_LEN/NUM_ROUNDS defaults SHALL live in the shared AES package.
REQ-038 The key store SHALL be one sub-module, rk_store: (NUM_ROUNDS+1) x KEY_LEN, one synchronous write port, one registered read port.

Verification
REQ-039 Use the real generator with key 2b7e151628aed2a6abf7158809cf4f3c and pulse start. Required:
  - store[1] = a0fafe1788542cb123a339392a6c7605;
  - store[10] = d014f9a8c9ee2589e13f0cc8b6630ca6;
  - one done pulse, then keys_valid=1.
REQ-040 During the REQ-039 run, check that gk_rcon steps 01000000 through 36000000 and is held constant throughout each WAIT.
REQ-041 With a stub generator that never asserts gk_valid_out: err pulses exactly TIMEOUT+1 cycles after the first issue, busy then falls and keys_valid=0.
REQ-042 Pulse start again in round 5 of a run: the schedule, done timing and store are unchanged.
REQ-043 Assert reset in round 4, then start with key 000102030405060708090a0b0c0d0e0f: store[10] = 13111d7fe3944a17f307a78b4d2b30c5.
REQ-044 Read rk_rd_addr=11 -> zeros. Read addr 0 after a run -> cipher_key one cycle later.
